// File: rtl/fetch_pc_unit_if.sv
// rtl/fetch_pc_unit_if.sv - F-stage PC / F-D register signal bundle
interface fetch_pc_unit_if;
    logic [31:0] npc;
    logic        stall;
    logic        req;
    logic        eret_clr;
    logic        bd_in;
    logic [31:0] im_instr;
    logic [31:0] im_addr;
    logic [31:0] F_PC;
    logic [31:0] D_PC;
    logic [31:0] D_instr;
    logic [4:0]  D_exccode;
    logic        D_bd;

    modport master (
        output npc, stall, req, eret_clr, bd_in, im_instr,
        input  im_addr, F_PC, D_PC, D_instr, D_exccode, D_bd
    );

    modport slave (
        input  npc, stall, req, eret_clr, bd_in, im_instr,
        output im_addr, F_PC, D_PC, D_instr, D_exccode, D_bd
    );
endinterface

// File: rtl/fetch_pc_unit.sv
// rtl/fetch_pc_unit.sv - F-stage PC and F/D pipeline register; FETCH_RANGE_CHECK_EN adds IM range AdEL
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_PC   = 32'h0000_4180,
    parameter logic [31:0] IM_LO    = 32'h0000_3000,
    parameter logic [31:0] IM_HI    = 32'h0000_6FFC
) (
    input  logic            clk,
    input  logic            reset,
    fetch_pc_unit_if.slave  bus
);
    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] f_pc_q, f_pc_d;
    logic [31:0] d_pc_q, d_pc_d;
    logic [31:0] d_instr_q, d_instr_d;
    logic [4:0]  d_exccode_q, d_exccode_d;
    logic        d_bd_q, d_bd_d;

    logic        f_misaligned;
    logic        f_out_of_range;
    logic        f_adel;

    assign f_misaligned   = (f_pc_q[1:0] != 2'b00);
    assign f_out_of_range = (f_pc_q < IM_LO) || (f_pc_q > IM_HI);

`ifdef FETCH_RANGE_CHECK_EN
    assign f_adel = f_misaligned || f_out_of_range;
`else
    // Without the range check, aligned fetches anywhere are taken as legal.
    logic unused_range;
    assign unused_range = f_out_of_range;
    assign f_adel       = f_misaligned;
`endif

    always_comb begin
        f_pc_d      = f_pc_q;
        d_pc_d      = d_pc_q;
        d_instr_d   = d_instr_q;
        d_exccode_d = d_exccode_q;
        d_bd_d      = d_bd_q;
        if (bus.req) begin
            // Flush: the F instruction is dropped even if D was stalled.
            f_pc_d      = bus.npc;
            d_pc_d      = EXC_PC;
            d_instr_d   = 32'h0;
            d_exccode_d = EXC_NONE;
            d_bd_d      = 1'b0;
        end else if (bus.stall) begin
            f_pc_d = f_pc_q;
        end else if (bus.eret_clr) begin
            // Squashed fetch never raises AdEL; it was never architecturally issued.
            f_pc_d      = bus.npc;
            d_pc_d      = f_pc_q;
            d_instr_d   = 32'h0;
            d_exccode_d = EXC_NONE;
            d_bd_d      = 1'b0;
        end else begin
            f_pc_d = bus.npc;
            d_pc_d = f_pc_q;
            d_bd_d = bus.bd_in;
            if (f_adel) begin
                d_instr_d   = 32'h0;
                d_exccode_d = EXC_ADEL;
            end else begin
                d_instr_d   = bus.im_instr;
                d_exccode_d = EXC_NONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_pc_q      <= RESET_PC;
            d_pc_q      <= RESET_PC;
            d_instr_q   <= 32'h0;
            d_exccode_q <= EXC_NONE;
            d_bd_q      <= 1'b0;
        end else begin
            f_pc_q      <= f_pc_d;
            d_pc_q      <= d_pc_d;
            d_instr_q   <= d_instr_d;
            d_exccode_q <= d_exccode_d;
            d_bd_q      <= d_bd_d;
        end
    end

    assign bus.im_addr   = f_pc_q;
    assign bus.F_PC      = f_pc_q;
    assign bus.D_PC      = d_pc_q;
    assign bus.D_instr   = d_instr_q;
    assign bus.D_exccode = d_exccode_q;
    assign bus.D_bd      = d_bd_q;
endmodule
